// File: rtl/instr_fetch_queue_if.sv
// instr_fetch_queue_if: fetch-stage, instruction-memory and decode-side signals of the fetch queue.
interface instr_fetch_queue_if;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  modport master (
    output pc_in, pc_valid, imem_ack, imem_rdata, flush, id_ready,
    input  pc_ready, imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc4
  );
  modport slave (
    input  pc_in, pc_valid, imem_ack, imem_rdata, flush, id_ready,
    output pc_ready, imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc4
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: single-outstanding instruction fetcher feeding a DEPTH-entry decode queue.
module instr_fetch_queue #(
  parameter int DEPTH = 2
) (
  input logic                Clock,
  input logic                Reset,
  instr_fetch_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
  state_t        r_state, w_next;
  logic [31:0]   r_addr, r_pc;
  logic [31:0]   r_instr_q [DEPTH];
  logic [31:0]   r_pc_q [DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_cnt, w_occ;
  logic          w_valid, w_pop, w_push, w_accept;
  assign w_valid  = r_cnt != '0;
  assign w_pop    = w_valid & bus.id_ready;
  assign w_occ    = r_cnt - CW'(w_pop);
  // Acceptance only counts the queue after this cycle's pop; reset gates the strobe immediately.
  assign w_accept = Reset & (r_state == IDLE) & bus.pc_valid & ~bus.flush & (w_occ < CW'(DEPTH));
  assign w_push   = (r_state == WAIT) & bus.imem_ack & ~bus.flush;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? WAIT : IDLE;
      WAIT:    w_next = bus.imem_ack ? IDLE : (bus.flush ? DROP : WAIT);
      DROP:    w_next = bus.imem_ack ? IDLE : DROP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_pc    <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr <= {bus.pc_in[31:2], 2'b00};
        r_pc   <= bus.pc_in;
      end
      if (bus.flush) begin
        r_rd  <= '0;
        r_wr  <= '0;
        r_cnt <= '0;
      end else begin
        r_rd  <= r_rd + AW'(w_pop);
        r_wr  <= r_wr + AW'(w_push);
        r_cnt <= w_occ + CW'(w_push);
      end
    end
  end
  always_ff @(posedge Clock) begin
    if (w_push) begin
      r_instr_q[r_wr] <= bus.imem_rdata;
      r_pc_q[r_wr]    <= r_pc;
    end
  end
  assign bus.pc_ready  = w_accept;
  assign bus.imem_req  = r_state != IDLE;
  assign bus.imem_addr = r_addr;
  assign bus.id_valid  = w_valid;
  assign bus.id_instr  = w_valid ? r_instr_q[r_rd] : '0;
  assign bus.id_pc     = w_valid ? r_pc_q[r_rd] : '0;
  assign bus.id_pc4    = w_valid ? r_pc_q[r_rd] + 32'd4 : '0;
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed scenarios with a scoreboard of expected decode entries.
module tb_instr_fetch_queue;
  logic Clock = 0;
  logic Reset = 1;
  instr_fetch_queue_if ifc();
  instr_fetch_queue #(.DEPTH(2)) dut (.Clock(Clock), .Reset(Reset), .bus(ifc.slave));
  always #10 Clock = ~Clock;
  typedef struct {logic [31:0] pc; logic [31:0] instr;} exp_t;
  exp_t sb[$];
  exp_t e;
  int total = 0, bad = 0, n_rdy = 0, n_req = 0, lat = 1, wcnt = 0;
  logic force_ack = 0, req_q = 0;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h1357, 16'hC0DE};
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, want);
    end
  endtask
  task automatic step();
    @(posedge Clock);
    #1;
  endtask
  task automatic wait_sig(input int w, input string n);
    logic ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge Clock);
      ok = (w == 0) ? ifc.pc_ready : (w == 1) ? ifc.imem_ack : ifc.id_valid;
    end
    chk(n, 32'(ok), 1);
  endtask
  task automatic issue(input logic [31:0] pc, input string n);
    step();
    ifc.pc_valid = 1;
    ifc.pc_in = pc;
    wait_sig(0, n);
    step();
    ifc.pc_valid = 0;
  endtask
  // Memory model: acks after lat extra request cycles; force_ack injects a stray ack.
  initial forever begin
    @(posedge Clock);
    #2;
    if (ifc.imem_req && wcnt == lat) begin
      ifc.imem_ack = 1;
      ifc.imem_rdata = mem_word(ifc.imem_addr);
      wcnt = 0;
    end else begin
      ifc.imem_ack = force_ack;
      ifc.imem_rdata = 32'hDEAD_BEEF;
      wcnt = ifc.imem_req ? wcnt + 1 : 0;
    end
  end
  initial forever begin
    @(negedge Clock);
    if (Reset) begin
      if (ifc.flush) sb.delete();
      else begin
        if (ifc.id_valid && ifc.id_ready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL mon_unexpected: got pc %h want no entry", ifc.id_pc);
          end else begin
            e = sb.pop_front();
            chk("mon_instr", ifc.id_instr, e.instr);
            chk("mon_pc", ifc.id_pc, e.pc);
            chk("mon_pc4", ifc.id_pc4, e.pc + 32'd4);
          end
        end
        if (ifc.pc_ready) begin
          sb.push_back('{ifc.pc_in, mem_word(ifc.pc_in & 32'hFFFF_FFFC)});
          n_rdy++;
        end
      end
      if (ifc.imem_req && !req_q) n_req++;
    end
    req_q = ifc.imem_req;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    int v, r0, q0;
    ifc.pc_in = 0;
    ifc.pc_valid = 0;
    ifc.imem_ack = 0;
    ifc.imem_rdata = 0;
    ifc.flush = 0;
    ifc.id_ready = 0;
    #2 Reset = 0;
    ifc.pc_valid = 1;
    #3;
    chk("rst_req", 32'(ifc.imem_req), 0);
    chk("rst_addr", ifc.imem_addr, 0);
    chk("rst_valid", 32'(ifc.id_valid), 0);
    chk("rst_instr", ifc.id_instr, 0);
    chk("rst_pc", ifc.id_pc, 0);
    chk("rst_pc4", ifc.id_pc4, 0);
    chk("rst_rdy", 32'(ifc.pc_ready), 0);
    ifc.pc_valid = 0;
    @(posedge Clock);
    #1 Reset = 1;
    // Basic fetch with a two-cycle memory.
    ifc.id_ready = 1;
    lat = 2;
    issue(32'h10, "s1_rdy");
    chk("s1_req", 32'(ifc.imem_req), 1);
    chk("s1_addr", ifc.imem_addr, 32'h10);
    wait_sig(1, "s1_ack");
    chk("s1_nobypass", 32'(ifc.id_valid), 0);
    @(negedge Clock);
    chk("s1_valid", 32'(ifc.id_valid), 1);
    chk("s1_pc", ifc.id_pc, 32'h10);
    chk("s1_pc4", ifc.id_pc4, 32'h14);
    chk("s1_instr", ifc.id_instr, 32'h1347_C0DE);
    chk("s1_rdy_count", n_rdy, 1);
    // Back-pressure: depth 2 stalls the third fetch until a pop.
    step();
    ifc.id_ready = 0;
    lat = 1;
    r0 = n_rdy;
    q0 = n_req;
    ifc.pc_valid = 1;
    ifc.pc_in = 32'h0;
    wait_sig(0, "s2_rdy0");
    step();
    ifc.pc_in = 32'h4;
    wait_sig(0, "s2_rdy4");
    step();
    ifc.pc_in = 32'h8;
    repeat (10) @(negedge Clock);
    chk("s2_rdy_count", n_rdy - r0, 2);
    chk("s2_req_count", n_req - q0, 2);
    chk("s2_full", 32'(ifc.id_valid), 1);
    chk("s2_blocked", 32'(ifc.pc_ready), 0);
    step();
    ifc.id_ready = 1;
    @(negedge Clock);
    chk("s2_rdy_on_pop", 32'(ifc.pc_ready), 1);
    step();
    ifc.id_ready = 0;
    ifc.pc_valid = 0;
    repeat (4) @(negedge Clock);
    chk("s2_req_count3", n_req - q0, 3);
    step();
    ifc.id_ready = 1;
    repeat (6) step();
    chk("s2_drained", sb.size(), 0);
    // Unaligned PC and PC+4 wrap.
    ifc.id_ready = 0;
    issue(32'h13, "s3_rdy");
    chk("s3_addr", ifc.imem_addr, 32'h10);
    wait_sig(2, "s3_valid");
    chk("s3_pc", ifc.id_pc, 32'h13);
    chk("s3_pc4", ifc.id_pc4, 32'h17);
    step();
    ifc.id_ready = 1;
    step();
    ifc.id_ready = 0;
    issue(32'hFFFF_FFFC, "s3_rdy2");
    chk("s3_addr2", ifc.imem_addr, 32'hFFFF_FFFC);
    wait_sig(2, "s3_valid2");
    chk("s3_pc_hi", ifc.id_pc, 32'hFFFF_FFFC);
    chk("s3_pc4_wrap", ifc.id_pc4, 32'h0);
    step();
    ifc.id_ready = 1;
    step();
    ifc.id_ready = 0;
    // Flush while waiting on memory.
    lat = 3;
    issue(32'h20, "s4_rdy");
    ifc.flush = 1;
    step();
    ifc.flush = 0;
    chk("s4_drop_req", 32'(ifc.imem_req), 1);
    v = 0;
    repeat (8) begin
      @(negedge Clock);
      if (ifc.id_valid) v++;
    end
    chk("s4_novalid", v, 0);
    chk("s4_idle_req", 32'(ifc.imem_req), 0);
    chk("s4_sb_empty", sb.size(), 0);
    // Full queue, pop and flush together.
    lat = 1;
    issue(32'h40, "s5_rdy0");
    issue(32'h44, "s5_rdy1");
    repeat (4) @(negedge Clock);
    chk("s5_full", 32'(ifc.id_valid), 1);
    chk("s5_head", ifc.id_pc, 32'h40);
    step();
    ifc.id_ready = 1;
    ifc.flush = 1;
    step();
    ifc.flush = 0;
    @(negedge Clock);
    chk("s5_empty", 32'(ifc.id_valid), 0);
    v = 0;
    repeat (5) begin
      @(negedge Clock);
      if (ifc.id_valid) v++;
    end
    chk("s5_no_reappear", v, 0);
    ifc.id_ready = 0;
    // Reset pulse mid-WAIT, then a stray ack.
    issue(32'h50, "s6_rdy0");
    wait_sig(2, "s6_valid0");
    lat = 6;
    issue(32'h54, "s6_rdy1");
    #2 Reset = 0;
    #1;
    chk("s6_req", 32'(ifc.imem_req), 0);
    chk("s6_addr", ifc.imem_addr, 0);
    chk("s6_valid", 32'(ifc.id_valid), 0);
    chk("s6_instr", ifc.id_instr, 0);
    chk("s6_pc", ifc.id_pc, 0);
    chk("s6_pc4", ifc.id_pc4, 0);
    chk("s6_rdy", 32'(ifc.pc_ready), 0);
    sb.delete();
    #1 Reset = 1;
    step();
    force_ack = 1;
    step();
    force_ack = 0;
    v = 0;
    repeat (5) begin
      @(negedge Clock);
      if (ifc.id_valid) v++;
    end
    chk("s6_stale_ack", v, 0);
    chk("s6_idle_req", 32'(ifc.imem_req), 0);
    lat = 1;
    ifc.id_ready = 1;
    issue(32'h60, "s6_rdy2");
    repeat (5) step();
    chk("s6_sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, meaning the number of fetched-instruction entries held for decode; only 2 and 4 are legal.
REQ-002 The block SHALL have port Clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1, asynchronous active-low reset (0 = reset).
REQ-004 The block SHALL have port pc_in, input, 32, the current PC driven by the fetch stage.
REQ-005 The block SHALL have port pc_valid, input, 1, meaning pc_in is a PC to fetch.
REQ-006 The block SHALL have port pc_ready, output, 1, a one-cycle strobe meaning pc_in was accepted and the fetch stage may advance its PC.
REQ-007 The block SHALL have port imem_req, output, 1, an instruction-memory read request.
REQ-008 The block SHALL have port imem_addr, output, 32, the word-aligned read address.
REQ-009 The block SHALL have port imem_ack, input, 1, meaning imem_rdata is valid this cycle and the request has completed.
REQ-010 The block SHALL have port imem_rdata, input, 32, the instruction word.
REQ-011 The block SHALL have port flush, input, 1, a branch-taken redirect that discards all queued and in-flight fetches.
REQ-012 The block SHALL have port id_valid, output, 1, meaning the queue head is valid for decode.
REQ-013 The block SHALL have port id_ready, input, 1, meaning decode consumes the head this cycle.
REQ-014 The block SHALL have ports id_instr, id_pc and id_pc4, outputs, 32 each, carrying the head instruction, its PC, and its PC+4.

Function
REQ-015 The control FSM SHALL have the states IDLE, WAIT (request outstanding) and DROP (outstanding request whose data is to be discarded).
REQ-016 In IDLE, with pc_valid=1, flush=0 and occupancy after this cycle's pop < DEPTH, the block SHALL assert pc_ready combinationally, latch imem_addr={pc_in[31:2],2'b00} and the full pc_in, and move to WAIT.
REQ-017 In WAIT and DROP, imem_req SHALL be 1 and imem_addr SHALL stay stable until the cycle in which imem_ack=1; outside these states imem_req SHALL be 0.
REQ-018 On imem_ack in WAIT with flush=0, the block SHALL push {latched pc, imem_rdata} into the queue and return to IDLE; the next request is issued no earlier than the following cycle.
REQ-019 On imem_ack in DROP, the block SHALL discard imem_rdata and return to IDLE.
REQ-020 The push SHALL become visible at the outputs one cycle after imem_ack: when the queue is empty, id_valid=1 in cycle ack+1, with no combinational bypass.
REQ-021 A pop SHALL occur when id_valid and id_ready are both 1; a pop and a push in the same cycle SHALL both take effect.
REQ-022 Overflow SHALL be impossible by construction: occupancy plus the outstanding request never exceeds DEPTH.
REQ-023 id_instr, id_pc and id_pc4 SHALL reflect the head entry when id_valid=1 and SHALL be 32'h0 when the queue is empty; id_pc4 = id_pc + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x0).
REQ-024 When flush=1, the queue SHALL be empty in the next cycle (any same-cycle pop or push is discarded), pc_ready SHALL be 0, WAIT SHALL move to DROP (or to IDLE if imem_ack is also 1), and DROP SHALL remain DROP (or move to IDLE on imem_ack).
REQ-025 Pointers SHALL wrap modulo DEPTH, and occupancy SHALL be tracked with log2(DEPTH)+1 bits.

Reset
REQ-026 When Reset=0, the block SHALL immediately set the state to IDLE, empty the queue, and drive imem_req=0, imem_addr=0, id_valid=0, id_instr=0, id_pc=0, id_pc4=0 and pc_ready=0.
REQ-027 A reset asserted while in WAIT SHALL abandon the transaction, and any imem_ack that arrives after reset release while in IDLE SHALL be ignored.

Verification
REQ-028 Scenario: pc_in=0x00000010 with pc_valid=1, imem_ack returned 2 cycles after imem_req, id_ready=1 -> pc_ready strobes once, imem_addr=0x10, and id_valid=1 with id_pc=0x10, id_pc4=0x14 and id_instr equal to the returned word, one cycle after the ack.
REQ-029 Scenario: DEPTH=2, id_ready=0, continuous pc_valid at PCs 0x0 and 0x4 -> exactly two fetches complete, no third imem_req is issued, and the third pc_ready is asserted only in the cycle of the first pop.
REQ-030 Scenario: flush asserted in WAIT with imem_ack arriving 3 cycles later -> state DROP, imem_req held at 1, data discarded, id_valid=0 throughout, then IDLE.
REQ-031 Scenario: full queue with a same-cycle pop and flush -> id_valid=0 in the next cycle and no entry reappears afterwards.
REQ-032 Scenario: pc_in=0x00000013 -> imem_addr=0x10 and id_pc=0x13; pc_in=0xFFFFFFFC -> id_pc4=0x00000000.
REQ-033 Scenario: Reset pulsed low mid-WAIT between clock edges -> all outputs go to 0 before the next edge, and a stale imem_ack after release causes no push.
